div_seq: RTL
============

Name: div_seq

Overview:
- Multi-cycle 32-bit integer divider for the EX stage; serves DIV and DIVU.
- Produces a 64-bit result: remainder goes to HI (bits 63:32) and quotient goes to LO (bits 31:0).
- The result travels through MEM and WB into the HI/LO register file.
- While start_i is high and ready_o is low, EX holds the pipeline stall request.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- signed_div_i  input  1  1 = signed division (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  WIDTH  dividend
- opdata2_i  input  WIDTH  divisor
- start_i  input  1  request division; held high by EX until the result is consumed
- annul_i  input  1  cancel the operation (flush or exception)
- result_o  output  2*WIDTH  {remainder, quotient}
- ready_o  output  1  result_o valid

Behaviour:
- Reset (rst high at a rising edge): state=FREE, counter=0, ready_o=0, result_o=0. Reset overrides every other input in every state, including mid-division.
- States: FREE, BYZERO, ON, END.
- FREE:
  - If start_i=1 and annul_i=0: latch operands. Go to BYZERO if opdata2_i==0, otherwise go to ON with counter=0.
  - Otherwise stay in FREE.
  - ready_o=0, result_o=0.
- Operand preparation, done at the accept edge:
  - If signed_div_i=1, negative operands are replaced by their two's-complement magnitude.
  - Remember the dividend sign and the quotient sign (dividend sign XOR divisor sign).
  - Operand inputs are ignored after the accept edge.
- ON:
  - One restoring shift-subtract step per cycle, using a (2*WIDTH+1)-bit partial register.
  - counter increments each step.
  - After WIDTH steps (counter==WIDTH), the next edge finalises: negate the quotient if the quotient sign is 1, negate the remainder if the dividend sign is 1. Then go to END.
- BYZERO: next edge goes to END with result 0.
- END:
  - ready_o=1; result_o holds the final value.
  - Stays in END while start_i=1.
  - When start_i=0, the next edge goes to FREE with ready_o=0 and result_o=0.
- Latency, counted from the accepting edge:
  - Normal division: ready_o=1 after exactly WIDTH+1 = 33 further edges.
  - Divide by zero: ready_o=1 after 1 further edge.
- annul_i:
  - In ON or BYZERO: next edge goes to FREE, counter=0, ready_o stays 0, no result is produced.
  - In FREE: a start is not accepted while annul_i=1.
  - In END: annul_i is ignored; exit from END is governed by start_i only.
- Boundary cases:
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000 (wraps), remainder 0. No trap.
  - Remainder sign always follows the dividend; a zero remainder is never negated into a nonzero value.
  - ready_o and result_o are registered outputs; there is no combinational path from any input.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN
- Defined:
  - At the accept edge, if |dividend| < |divisor| (unsigned compare of magnitudes, divisor nonzero), or if dividend==0, skip ON.
  - The next edge goes to END with quotient=0 and remainder = the original signed dividend.
  - ready_o then asserts 1 edge after accept.
  - Divide-by-zero still takes the BYZERO path.
- Not defined: every nonzero-divisor division takes the full 33-cycle ON path. Results are bit-identical in both builds; only latency differs.

Test Plan:
- DIVU 100 / 7, start held: ready_o rises 33 cycles after accept, result_o = 0x00000002_0000000E. start_i dropped -> next cycle ready_o=0, result_o=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> result_o = 0xFFFFFFFF_FFFFFFFD (remainder -1, quotient -3). DIV 7 / 0xFFFFFFFE (-2) -> 0x00000001_FFFFFFFD.
- DIVU 5 / 0 -> ready_o rises 1 cycle after accept, result_o = 0. DIV 0x80000000 / 0xFFFFFFFF -> result_o = 0x00000000_80000000.
- Start DIVU 1000 / 3 and assert annul_i for one cycle, 10 cycles in -> FREE next cycle, ready_o never rises. A new DIVU 9 / 4 then returns 0x00000001_00000002 after 33 cycles.
- rst asserted for one cycle at step 20 of a division -> ready_o=0, result_o=0 on the next edge. A subsequent division completes with correct latency and value.
- Built with DIV_EARLY_OUT_EN: DIVU 3 / 10 -> ready_o rises 1 cycle after accept, result_o = 0x00000003_00000000. Built without the macro: same result after 33 cycles.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for DIV/DIVU, result = {remainder, quotient}.
// Optional build macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int unsigned PW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      partial_q, partial_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [PW-1:0]      shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo_fin, rem_fin;

    // Magnitudes of the incoming operands (only meaningful at the accept edge).
    assign mag_a = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    assign mag_b = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

    // Partial register layout: {remainder (WIDTH+1), quotient/dividend (WIDTH)}.
    assign shifted = partial_q << 1;
    assign trial   = shifted[PW-1:WIDTH] - {1'b0, divisor_q};

    assign quo_fin = neg_quot_q ? (~partial_q[WIDTH-1:0] + WIDTH'(1)) : partial_q[WIDTH-1:0];
    assign rem_fin = neg_rem_q ? (~partial_q[2*WIDTH-1:WIDTH] + WIDTH'(1))
                               : partial_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        partial_d  = partial_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                cnt_d    = '0;
                if (start_i && !annul_i) begin
                    divisor_d  = mag_b;
                    neg_quot_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d  = signed_div_i && opdata1_i[WIDTH-1];
                    partial_d  = {{(WIDTH + 1){1'b0}}, mag_a};
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d = S_ON;
`ifdef DIV_EARLY_OUT_EN
                        // Quotient is zero: preload the finished state so the next edge finalises.
                        if (mag_a < mag_b) begin
                            cnt_d     = CNT_W'(WIDTH);
                            partial_d = {1'b0, mag_a, {WIDTH{1'b0}}};
                        end
`endif
                    end
                end
            end

            S_BYZERO: begin
                cnt_d = '0;
                if (annul_i) begin
                    state_d = S_FREE;
                end else begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end

            S_ON: begin
                if (annul_i) begin
                    state_d = S_FREE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d  = S_END;
                    cnt_d    = '0;
                    ready_d  = 1'b1;
                    result_d = {rem_fin, quo_fin};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!trial[WIDTH]) begin
                        partial_d = {trial, shifted[WIDTH-1:0] | WIDTH'(1)};
                    end else begin
                        partial_d = shifted;
                    end
                end
            end

            S_END: begin
                if (!start_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = S_FREE;
                cnt_d    = '0;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FREE;
            cnt_q      <= '0;
            partial_q  <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            partial_q  <= partial_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
